// File: rtl/sig_burst_pkg.sv
// Shared types and defaults for the two-line toggle-burst checker.
package sig_burst_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic SIG1_IDLE = 1'b0;
  localparam logic SIG2_IDLE = 1'b1;

  localparam int BURST_LEN_DEF = 10;
  localparam int IDLE_GAP_DEF  = 2;
  localparam int MAX_SKEW_DEF  = 1;
  localparam int CW_DEF        = 8;

endpackage

// File: rtl/sig_burst_checker_tracker.sv
// Per-line toggle detect, saturating toggle count and gap (resume-after-pause) detect.
module line_toggle_tracker #(
  parameter int   CW       = 8,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sig,
  input  logic          clr,
  input  logic          en,
  output logic          tog,
  output logic [CW-1:0] cnt,
  output logic          started,
  output logic          gap
);

  logic prev;
  logic stopped;

  assign tog = sig ^ prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev    <= IDLE_LVL;
      cnt     <= '0;
      started <= 1'b0;
      stopped <= 1'b0;
      gap     <= 1'b0;
    end else begin
      prev <= sig;
      // Entry sample clears the working state but still counts its own toggle.
      if (clr) begin
        cnt     <= {{(CW-1){1'b0}}, tog};
        started <= tog;
        stopped <= 1'b0;
        gap     <= 1'b0;
      end else if (en) begin
        if (tog) begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          started <= 1'b1;
          if (stopped) gap <= 1'b1;
        end else if (started) begin
          stopped <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sig_burst_checker.sv
// Burst detector/checker: counts toggles per line, checks length, skew and contiguity,
// and reports one registered verdict per burst with a one-cycle done pulse.
module sig_burst_checker
  import sig_burst_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int IDLE_GAP  = IDLE_GAP_DEF,
  parameter int MAX_SKEW  = MAX_SKEW_DEF,
  parameter int CW        = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sig1,
  input  logic          sig2,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          len_err1,
  output logic          len_err2,
  output logic          skew_err,
  output logic          gap_err,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2
);

  localparam logic [CW-1:0] LEN_REF  = CW'(BURST_LEN);
  localparam logic [CW-1:0] GAP_LIM  = CW'(IDLE_GAP);
  localparam logic [CW-1:0] SKEW_LIM = CW'(MAX_SKEW);

  state_t        state;
  logic          t1, t2, st1, st2, g1, g2;
  logic [CW-1:0] wc1, wc2;
  logic [CW-1:0] qcnt, skew_cnt;
  logic          skew_run, skew_w;
  logic          entry, en;
  logic          le1, le2, sk, ge;

  assign entry = (state == IDLE) && (t1 || t2);
  assign en    = (state == BURST);

  line_toggle_tracker #(.CW(CW), .IDLE_LVL(SIG1_IDLE)) u_trk1 (
    .clk(clk), .rst(rst), .sig(sig1), .clr(entry), .en(en),
    .tog(t1), .cnt(wc1), .started(st1), .gap(g1)
  );

  line_toggle_tracker #(.CW(CW), .IDLE_LVL(SIG2_IDLE)) u_trk2 (
    .clk(clk), .rst(rst), .sig(sig2), .clr(entry), .en(en),
    .tog(t2), .cnt(wc2), .started(st2), .gap(g2)
  );

  assign le1 = (wc1 != LEN_REF);
  assign le2 = (wc2 != LEN_REF);
  // A line that never toggled is the limiting case of unbounded skew.
  assign sk  = skew_w || !(st1 && st2);
  assign ge  = g1 || g2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      len_err1 <= 1'b0;
      len_err2 <= 1'b0;
      skew_err <= 1'b0;
      gap_err  <= 1'b0;
      cnt1     <= '0;
      cnt2     <= '0;
      qcnt     <= '0;
      skew_cnt <= '0;
      skew_run <= 1'b0;
      skew_w   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (t1 || t2) begin
            state    <= BURST;
            busy     <= 1'b1;
            qcnt     <= '0;
            skew_cnt <= '0;
            skew_run <= (t1 ^ t2) && (MAX_SKEW != 0);
            skew_w   <= (t1 ^ t2) && (MAX_SKEW == 0);
          end
        end
        BURST: begin
          if (t1 || t2)                   qcnt  <= '0;
          else if (qcnt + 1'b1 >= GAP_LIM) state <= REPORT;
          else                            qcnt  <= qcnt + 1'b1;
          // skew_cnt + 1 is the distance of this sample from the first toggle.
          if (skew_run) begin
            if (st1 ? t2 : t1) begin
              skew_run <= 1'b0;
            end else if (skew_cnt + 1'b1 >= SKEW_LIM) begin
              skew_w   <= 1'b1;
              skew_run <= 1'b0;
            end else begin
              skew_cnt <= skew_cnt + 1'b1;
            end
          end
        end
        REPORT: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
          cnt1     <= wc1;
          cnt2     <= wc2;
          len_err1 <= le1;
          len_err2 <= le2;
          skew_err <= sk;
          gap_err  <= ge;
          pass     <= !(le1 || le2 || sk || ge);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
